// File: rtl/text_console_writer.sv
// text_console_writer
// Terminal-style byte writer for a ROWS x COLS character plane. Accepts one
// byte per valid/ready handshake, keeps a cursor, writes printable bytes at
// the cursor, handles LF/CR/BS/FF and scrolls the plane via push_up when the
// cursor runs off the bottom row.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   in_valid, in_data   : byte source (character id or control code)
//   in_ready            : high only while IDLE; transfer on in_valid & in_ready
//   we, w_row, w_column,
//   w_character_id      : registered plane write port
//   push_up             : registered one-cycle scroll pulse to the plane
//   cursor_row/column   : current cursor position
//   busy                : high in any state other than IDLE
module text_console_writer #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       we,
  output logic [3:0] w_row,
  output logic [5:0] w_column,
  output logic [7:0] w_character_id,
  output logic       push_up,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_column,
  output logic       busy
);

  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 6;
  localparam int unsigned DAT_W = 8;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  localparam logic [DAT_W-1:0] CODE_BS = 8'h08;
  localparam logic [DAT_W-1:0] CODE_LF = 8'h0A;
  localparam logic [DAT_W-1:0] CODE_FF = 8'h0C;
  localparam logic [DAT_W-1:0] CODE_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_SCROLL = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  state_t             r_state,   w_state_nx;
  logic [ROW_W-1:0]   r_cur_row, w_cur_row_nx;
  logic [COL_W-1:0]   r_cur_col, w_cur_col_nx;
  logic               r_scroll_pend, w_scroll_pend_nx;
  logic               r_we,      w_we_nx;
  logic [ROW_W-1:0]   r_w_row,   w_w_row_nx;
  logic [COL_W-1:0]   r_w_col,   w_w_col_nx;
  logic [DAT_W-1:0]   r_w_data,  w_w_data_nx;
  logic               r_push_up, w_push_up_nx;

  // State, cursor and registered plane-port outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cur_row     <= '0;
      r_cur_col     <= '0;
      r_scroll_pend <= 1'b0;
      r_we          <= 1'b0;
      r_w_row       <= '0;
      r_w_col       <= '0;
      r_w_data      <= '0;
      r_push_up     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cur_row     <= w_cur_row_nx;
      r_cur_col     <= w_cur_col_nx;
      r_scroll_pend <= w_scroll_pend_nx;
      r_we          <= w_we_nx;
      r_w_row       <= w_w_row_nx;
      r_w_col       <= w_w_col_nx;
      r_w_data      <= w_w_data_nx;
      r_push_up     <= w_push_up_nx;
    end
  end

  // Next-state, cursor update and plane-port values.
  always_comb begin
    w_state_nx       = r_state;
    w_cur_row_nx     = r_cur_row;
    w_cur_col_nx     = r_cur_col;
    w_scroll_pend_nx = r_scroll_pend;
    w_we_nx          = 1'b0;
    w_w_row_nx       = r_w_row;
    w_w_col_nx       = r_w_col;
    w_w_data_nx      = r_w_data;
    w_push_up_nx     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nx       = S_WRITE;
          w_scroll_pend_nx = 1'b0;
          case (in_data)
            CODE_LF: begin
              w_cur_col_nx = '0;
              // Bottom row: the cursor stays put and the plane scrolls instead.
              if (r_cur_row == LAST_ROW) w_scroll_pend_nx = 1'b1;
              else                       w_cur_row_nx     = r_cur_row + ROW_W'(1);
            end
            CODE_CR: begin
              w_cur_col_nx = '0;
            end
            CODE_BS: begin
              // Step back one cell (with row borrow) and blank it; no-op at home.
              if (r_cur_col != '0) begin
                w_cur_col_nx = r_cur_col - COL_W'(1);
                w_we_nx      = 1'b1;
                w_w_row_nx   = r_cur_row;
                w_w_col_nx   = r_cur_col - COL_W'(1);
                w_w_data_nx  = '0;
              end else if (r_cur_row != '0) begin
                w_cur_row_nx = r_cur_row - ROW_W'(1);
                w_cur_col_nx = LAST_COL;
                w_we_nx      = 1'b1;
                w_w_row_nx   = r_cur_row - ROW_W'(1);
                w_w_col_nx   = LAST_COL;
                w_w_data_nx  = '0;
              end
            end
            CODE_FF: begin
              // First clear write goes out with the same latency as a normal write.
              w_state_nx   = S_CLEAR;
              w_cur_row_nx = '0;
              w_cur_col_nx = '0;
              w_we_nx      = 1'b1;
              w_w_row_nx   = '0;
              w_w_col_nx   = '0;
              w_w_data_nx  = '0;
            end
            default: begin
              w_we_nx     = 1'b1;
              w_w_row_nx  = r_cur_row;
              w_w_col_nx  = r_cur_col;
              w_w_data_nx = in_data;
              if (r_cur_col == LAST_COL) begin
                w_cur_col_nx = '0;
                if (r_cur_row == LAST_ROW) w_scroll_pend_nx = 1'b1;
                else                       w_cur_row_nx     = r_cur_row + ROW_W'(1);
              end else begin
                w_cur_col_nx = r_cur_col + COL_W'(1);
              end
            end
          endcase
        end
      end

      S_WRITE: begin
        if (r_scroll_pend) begin
          w_state_nx       = S_SCROLL;
          w_push_up_nx     = 1'b1;
          w_scroll_pend_nx = 1'b0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end

      S_SCROLL: begin
        w_state_nx = S_IDLE;
      end

      S_CLEAR: begin
        // Walk the write address row-major; stop after the last cell is out.
        if ((r_w_row == LAST_ROW) && (r_w_col == LAST_COL)) begin
          w_state_nx = S_IDLE;
        end else begin
          w_we_nx     = 1'b1;
          w_w_data_nx = '0;
          if (r_w_col == LAST_COL) begin
            w_w_col_nx = '0;
            w_w_row_nx = r_w_row + ROW_W'(1);
          end else begin
            w_w_col_nx = r_w_col + COL_W'(1);
          end
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign in_ready       = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign we             = r_we;
  assign w_row          = r_w_row;
  assign w_column       = r_w_col;
  assign w_character_id = r_w_data;
  assign push_up        = r_push_up;
  assign cursor_row     = r_cur_row;
  assign cursor_column  = r_cur_col;

endmodule
